// File: rtl/hwy_req_arbiter.sv
// hwy_req_arbiter
//   Front end of the highway light controller. Synchronises and debounces the
//   raw secondary-road sensor and pedestrian button, latches each debounced
//   rising edge as a pending request, and offers at most one request at a time
//   on S/P. When both are pending, the source that was not served last wins.
//   After every serve, the highway green is held for GAP_TICKS ticks.
//
// Ports
//   Clock, Resetn      clock, asynchronous active-low reset
//   Tick               one-cycle timebase enable for all counters
//   SensorRaw, PedRaw  raw asynchronous inputs
//   Grant              controller pulse: the offered request has been served
//   S, P               one-hot request outputs (registered)
//   Q                  last served source: 1 = secondary, 0 = pedestrian
//   PendS, PendP       latched requests that have not been served yet
//   Err                sticky SERVE timeout flag
//
// Build option
//   HWY_ARB_TIMEOUT_EN  abandons a request after TIMEOUT_TICKS ticks in SERVE
//                       without a Grant. When the macro is undefined, no timeout
//                       counter is built and Err is tied to 0.
module hwy_req_arbiter #(
    parameter int DB_TICKS      = 4,
    parameter int GAP_TICKS     = 8,
    parameter int TIMEOUT_TICKS = 200
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic Tick,
    input  logic SensorRaw,
    input  logic PedRaw,
    input  logic Grant,
    output logic S,
    output logic P,
    output logic Q,
    output logic PendS,
    output logic PendP,
    output logic Err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam logic [3:0] DB_MAX  = 4'(DB_TICKS);
    localparam logic [7:0] GAP_MAX = 8'(GAP_TICKS);

    // Bit 0 is the secondary sensor and bit 1 is the pedestrian button.
    logic [1:0]      raw, sync1, sync2, deb, deb_prev, rise;
    logic [1:0][3:0] db_cnt;

    logic [1:0] state;
    logic       win_s;    // current winner: 1 = secondary, 0 = pedestrian
    logic [7:0] gap_cnt;
    logic       serve_done, timeout, leave;

    assign raw  = {PedRaw, SensorRaw};
    assign rise = deb & ~deb_prev;

    // The counter only runs while the synced input disagrees with the
    // debounced level. It saturates at DB_MAX. The flip on the following clock
    // makes the two levels equal again, and that clears the counter.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            db_cnt   <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] == DB_MAX)
                    deb[i] <= sync2[i];
                else if (Tick)
                    db_cnt[i] <= db_cnt[i] + 4'd1;
            end
        end
    end

    assign serve_done = (state == SERVE) && Grant;
    assign leave      = serve_done || timeout;

`ifdef HWY_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_MAX = 8'(TIMEOUT_TICKS);
    logic [7:0] to_cnt;

    // A Grant on the same cycle as the timeout takes priority, so it counts as a normal serve.
    assign timeout = (state == SERVE) && !Grant && (to_cnt == TO_MAX);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            to_cnt <= '0;
            Err    <= 1'b0;
        end else begin
            if (state != SERVE)
                to_cnt <= '0;
            else if (Tick && to_cnt != TO_MAX)
                to_cnt <= to_cnt + 8'd1;
            if (timeout)
                Err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign Err     = 1'b0;
`endif

    // A new edge takes priority over a clear in the same cycle, so the request is not lost.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            PendS <= 1'b0;
            PendP <= 1'b0;
        end else begin
            PendS <= rise[0] | (PendS & ~(leave &  win_s));
            PendP <= rise[1] | (PendP & ~(leave & ~win_s));
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            win_s   <= 1'b0;
            S       <= 1'b0;
            P       <= 1'b0;
            Q       <= 1'b1;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (PendS || PendP) begin
                        // On a tie, the source that was not served last wins.
                        win_s <= PendS & (~PendP | ~Q);
                        S     <= PendS & (~PendP | ~Q);
                        P     <= PendP & (~PendS |  Q);
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (leave) begin
                        S       <= 1'b0;
                        P       <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                        if (serve_done)
                            Q <= win_s;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_MAX)
                        state <= IDLE;
                    else if (Tick)
                        gap_cnt <= gap_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hwy_req_arbiter.sv
// Directed bench for hwy_req_arbiter: DB_TICKS=4, GAP_TICKS=8, TIMEOUT_TICKS=5,
// Tick once every 4 clocks. Outputs are sampled on the falling clock edge.
module tb_hwy_req_arbiter;
    logic Clock = 1'b0;
    logic Resetn, Tick, SensorRaw, PedRaw, Grant;
    logic S, P, Q, PendS, PendP, Err;
    int   total = 0;
    int   bad   = 0;

    hwy_req_arbiter #(.DB_TICKS(4), .GAP_TICKS(8), .TIMEOUT_TICKS(5)) dut (
        .Clock(Clock), .Resetn(Resetn), .Tick(Tick), .SensorRaw(SensorRaw),
        .PedRaw(PedRaw), .Grant(Grant), .S(S), .P(P), .Q(Q),
        .PendS(PendS), .PendP(PendP), .Err(Err)
    );

    always #5 Clock = ~Clock;

    initial begin
        Tick = 1'b0;
        forever begin
            repeat (3) @(negedge Clock);
            Tick = 1'b1;
            @(negedge Clock);
            Tick = 1'b0;
        end
    end

    task automatic pulse_grant();
        Grant = 1'b1;
        @(negedge Clock);
        Grant = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        int n;
        Resetn = 1'b0; PedRaw = 1'b1; SensorRaw = 1'b0; Grant = 1'b0;
        repeat (3) @(negedge Clock);
        total++;
        if ({S, P, PendS, PendP, Q, Err} !== 6'b000010) begin
            bad++; $display("FAIL reset_state got=%b want=000010", {S, P, PendS, PendP, Q, Err});
        end
        Resetn = 1'b1;
        seen = 0;
        repeat (12) begin @(negedge Clock); if (P === 1'b1) seen = 1; end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL reset_early_p got=%0d want=0", seen); end
        n = 0;
        while (P !== 1'b1 && n < 40) begin @(negedge Clock); n++; end
        total++;
        if ({P, S, PendP, Q} !== 4'b1011) begin
            bad++; $display("FAIL reset_p_offer got=%b want=1011", {P, S, PendP, Q});
        end
        pulse_grant();
        total++;
        if ({P, PendP, Q} !== 3'b000) begin
            bad++; $display("FAIL reset_p_grant got=%b want=000", {P, PendP, Q});
        end
        PedRaw = 1'b0;
        repeat (30) @(negedge Clock);
    endtask

    task automatic test_glitch();
        int seen = 0;
        PedRaw = 1'b1;
        repeat (12) begin @(negedge Clock); if (S | P | PendP) seen = 1; end
        PedRaw = 1'b0;
        repeat (40) begin @(negedge Clock); if (S | P | PendP) seen = 1; end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL glitch_ignored got=%0d want=0", seen); end
    endtask

    task automatic test_single();
        int n = 0;
        int seen = 0;
        SensorRaw = 1'b1;
        while (PendS !== 1'b1 && n < 50) begin @(negedge Clock); n++; end
        total++;
        if ({PendS, S} !== 2'b10) begin bad++; $display("FAIL single_pend got=%b want=10", {PendS, S}); end
        @(negedge Clock);
        total++;
        if ({S, P} !== 2'b10) begin bad++; $display("FAIL single_offer got=%b want=10", {S, P}); end
        pulse_grant();
        total++;
        if ({S, PendS, Q} !== 3'b001) begin
            bad++; $display("FAIL single_grant got=%b want=001", {S, PendS, Q});
        end
        repeat (28) begin @(negedge Clock); if (S | P) seen = 1; end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL single_gap got=%0d want=0", seen); end
        SensorRaw = 1'b0;
        repeat (30) @(negedge Clock);
    endtask

    task automatic test_tie();
        int n = 0;
        int seen = 0;
        SensorRaw = 1'b1; PedRaw = 1'b1;
        while (P !== 1'b1 && n < 50) begin @(negedge Clock); n++; end
        total++;
        if ({P, S, PendS, PendP} !== 4'b1011) begin
            bad++; $display("FAIL tie_p_first got=%b want=1011", {P, S, PendS, PendP});
        end
        pulse_grant();
        total++;
        if ({P, PendP, PendS, Q} !== 4'b0010) begin
            bad++; $display("FAIL tie_p_grant got=%b want=0010", {P, PendP, PendS, Q});
        end
        repeat (28) begin @(negedge Clock); if (S | P) seen = 1; end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL tie_gap got=%0d want=0", seen); end
        n = 0;
        while (S !== 1'b1 && n < 15) begin @(negedge Clock); n++; end
        total++;
        if ({S, P} !== 2'b10) begin bad++; $display("FAIL tie_s_second got=%b want=10", {S, P}); end
        pulse_grant();
        total++;
        if ({S, PendS, Q} !== 3'b001) begin
            bad++; $display("FAIL tie_s_grant got=%b want=001", {S, PendS, Q});
        end
        SensorRaw = 1'b0; PedRaw = 1'b0;
        repeat (30) @(negedge Clock);
    endtask

    task automatic test_simultaneous();
        int n = 0;
        int seen = 0;
        PedRaw = 1'b1;
        while (P !== 1'b1 && n < 60) begin @(negedge Clock); n++; end
        total++;
        if (P !== 1'b1) begin bad++; $display("FAIL simul_offer got=%b want=1", P); end
        PedRaw = 1'b0;
        repeat (30) @(negedge Clock);
        // Align to a Tick edge T0. The new debounced edge sets PendP at T0+18,
        // which is the edge on which Grant is sampled.
        n = 0;
        do begin @(posedge Clock); n++; end while (Tick !== 1'b1 && n < 10);
        @(negedge Clock);
        PedRaw = 1'b1;
        repeat (17) @(negedge Clock);
        pulse_grant();
        total++;
        if ({P, PendP, Q} !== 3'b010) begin
            bad++; $display("FAIL simul_set_wins got=%b want=010", {P, PendP, Q});
        end
        repeat (28) begin @(negedge Clock); if (S | P) seen = 1; end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL simul_gap got=%0d want=0", seen); end
        n = 0;
        while (P !== 1'b1 && n < 15) begin @(negedge Clock); n++; end
        total++;
        if ({P, S} !== 2'b10) begin bad++; $display("FAIL simul_reoffer got=%b want=10", {P, S}); end
        pulse_grant();
        total++;
        if ({P, PendP, Q} !== 3'b000) begin
            bad++; $display("FAIL simul_grant got=%b want=000", {P, PendP, Q});
        end
        PedRaw = 1'b0;
        repeat (30) @(negedge Clock);
    endtask

    task automatic test_timeout();
        int n = 0;
        SensorRaw = 1'b1;
        while (S !== 1'b1 && n < 60) begin @(negedge Clock); n++; end
        total++;
        if ({S, PendS, Err} !== 3'b110) begin
            bad++; $display("FAIL to_offer got=%b want=110", {S, PendS, Err});
        end
`ifdef HWY_ARB_TIMEOUT_EN
        repeat (15) @(negedge Clock);
        total++;
        if (S !== 1'b1) begin bad++; $display("FAIL to_early got=%b want=1", S); end
        n = 0;
        while (S !== 1'b0 && n < 15) begin @(negedge Clock); n++; end
        total++;
        if ({S, PendS, Err, Q} !== 4'b0010) begin
            bad++; $display("FAIL to_abandon got=%b want=0010", {S, PendS, Err, Q});
        end
`else
        repeat (40) @(negedge Clock);
        total++;
        if ({S, PendS, Err} !== 3'b110) begin
            bad++; $display("FAIL to_hold got=%b want=110", {S, PendS, Err});
        end
`endif
    endtask

    task automatic test_reset_mid_serve();
        int n = 0;
        SensorRaw = 1'b0;
        repeat (30) @(negedge Clock);
        SensorRaw = 1'b1;
        while (S !== 1'b1 && n < 60) begin @(negedge Clock); n++; end
        total++;
        if (S !== 1'b1) begin bad++; $display("FAIL rst_mid_offer got=%b want=1", S); end
        #2 Resetn = 1'b0;
        #1;
        total++;
        if ({S, P, PendS, Q, Err} !== 5'b00010) begin
            bad++; $display("FAIL rst_mid_async got=%b want=00010", {S, P, PendS, Q, Err});
        end
        @(negedge Clock);
        Resetn = 1'b1;
        SensorRaw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_tie();
        test_simultaneous();
        test_timeout();
        test_reset_mid_serve();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
